counter_asmd_seq_ctrl: RTL and testbench

//  ASMD control unit that sequences the 1E6 up/down counter datapath.
//  - Drives load, enable and direction; watches the datapath terminal-count (Cnt_tc).
//  - Runs the counter for a programmed number of full count periods, then signals Done.
//  - Sits between the test/control logic (Go/Stop/Dir_sel) and the counter datapath.

---
 rtl/counter_asmd_seq_ctrl_if.sv | 27 ++
 rtl/counter_asmd_seq_ctrl.sv | 84 ++++++++
 tb/tb_counter_asmd_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_asmd_seq_ctrl_if.sv
// Control/datapath bundle for counter_asmd_seq_ctrl: request side (Go/Stop/Dir_sel/Periods),
// datapath feedback (Cnt_tc) and the sequencer's strobes and status.
interface counter_asmd_seq_ctrl_if #(
  parameter int unsigned PW = 8
);
  logic          Go;
  logic          Stop;
  logic          Dir_sel;
  logic [PW-1:0] Periods;
  logic          Cnt_tc;
  logic          Cnt_ld;
  logic          Cnt_en;
  logic          Cnt_up;
  logic          Busy;
  logic          Done;
  logic [PW-1:0] Period_cnt;

  modport master (
    output Go, Stop, Dir_sel, Periods, Cnt_tc,
    input  Cnt_ld, Cnt_en, Cnt_up, Busy, Done, Period_cnt
  );

  modport slave (
    input  Go, Stop, Dir_sel, Periods, Cnt_tc,
    output Cnt_ld, Cnt_en, Cnt_up, Busy, Done, Period_cnt
  );
endinterface

// File: rtl/counter_asmd_seq_ctrl.sv
// ASMD sequencer for the up/down counter datapath: load, run for P_lat terminal counts, pulse Done.
// Optional AUTO_RELOAD_EN: DONE reloads and repeats the run with the same P_lat until Stop.
module counter_asmd_seq_ctrl #(
  parameter int unsigned PW = 8
) (
  input  logic                     CLK,
  input  logic                     Clrn,
  counter_asmd_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] p_lat;
  logic [PW-1:0] period_cnt;
  logic [PW-1:0] cnt_inc;
  logic          cnt_up;

  assign cnt_inc = period_cnt + PW'(1);

  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      state      <= IDLE;
      p_lat      <= '0;
      period_cnt <= '0;
      cnt_up     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Go && (bus.Periods != '0)) begin
            state      <= LOAD;
            p_lat      <= bus.Periods;
            period_cnt <= '0;
            cnt_up     <= bus.Dir_sel;
          end
        end
        LOAD: begin
          cnt_up <= bus.Dir_sel;
          state  <= bus.Stop ? IDLE : RUN;
        end
        RUN: begin
          cnt_up <= bus.Dir_sel;
          // Stop outranks a coincident terminal count, which then goes uncounted.
          if (bus.Stop) begin
            state <= IDLE;
          end else if (bus.Cnt_tc) begin
            period_cnt <= cnt_inc;
            if (cnt_inc == p_lat) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
`ifdef AUTO_RELOAD_EN
          if (bus.Stop) begin
            state <= IDLE;
          end else begin
            state      <= LOAD;
            period_cnt <= '0;
            cnt_up     <= bus.Dir_sel;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from the state register alone.
  assign bus.Cnt_ld     = (state == LOAD);
  assign bus.Cnt_en     = (state == RUN);
  assign bus.Busy       = (state == LOAD) || (state == RUN);
  assign bus.Done       = (state == DONE);
  assign bus.Cnt_up     = cnt_up;
  assign bus.Period_cnt = period_cnt;

endmodule

// File: tb/tb_counter_asmd_seq_ctrl.sv
// Bench for counter_asmd_seq_ctrl: mod-10 counter model closes the loop; run outcomes go through a scoreboard.
module tb_counter_asmd_seq_ctrl;

  localparam int unsigned PW = 8;

  logic CLK = 1'b0;
  logic Clrn;

  counter_asmd_seq_ctrl_if #(.PW(PW)) bus ();

  counter_asmd_seq_ctrl #(.PW(PW)) dut (
    .CLK  (CLK),
    .Clrn (Clrn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          done;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Mod-10 up/down counter datapath; terminal count flags the wrap value while enabled.
  int unsigned mcnt = 0;
  always @(posedge CLK) begin
    if (bus.Cnt_ld === 1'b1)
      mcnt <= (bus.Cnt_up === 1'b1) ? 0 : 9;
    else if (bus.Cnt_en === 1'b1) begin
      if (bus.Cnt_up === 1'b1) mcnt <= (mcnt == 9) ? 0 : mcnt + 1;
      else                     mcnt <= (mcnt == 0) ? 9 : mcnt - 1;
    end
  end
  assign bus.Cnt_tc = (bus.Cnt_en === 1'b1) &&
                      ((bus.Cnt_up === 1'b1) ? (mcnt == 9) : (mcnt == 0));

  // Terminal counts that a run should credit: pulses seen while enabled and not aborted.
  int unsigned tc_run = 0;
  always @(posedge CLK) begin
    if (!Clrn || bus.Cnt_ld === 1'b1) tc_run <= 0;
    else if (bus.Cnt_tc && bus.Stop !== 1'b1) tc_run <= tc_run + 1;
  end

  // Monitor: every end of run (Done pulse or Busy dropping without Done) pops one expectation.
  bit busy_prev = 1'b0;

  task automatic end_of_run(input bit obs_done);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got run end done=%0d cnt=%0d expected no run end at %0t",
               obs_done, bus.Period_cnt, $time);
    end else begin
      e = sb.pop_front();
      chk("run_done_flag", 32'(obs_done), 32'(e.done));
      chk("run_period_cnt", 32'(bus.Period_cnt), e.cnt);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.Done === 1'b1) end_of_run(1'b1);
    else if (busy_prev && bus.Busy === 1'b0) end_of_run(1'b0);
    busy_prev = (bus.Busy === 1'b1);
    if (Clrn && bus.Cnt_en === 1'b1) chk("period_cnt_track", 32'(bus.Period_cnt), tc_run);
  end

  task automatic push_exp(input bit done, input int unsigned cnt);
    exp_t e;
    e.done = done;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic start_run(input int unsigned p, input bit dir);
    @(negedge CLK);
    bus.Periods = PW'(p);
    bus.Dir_sel = dir;
    bus.Go      = 1'b1;
    @(posedge CLK);
    #1 bus.Go = 1'b0;
    @(negedge CLK);
    chk("load_strobe", 32'(bus.Cnt_ld), 1);
    chk("load_busy", 32'(bus.Busy), 1);
    chk("load_no_en", 32'(bus.Cnt_en), 0);
    chk("load_dir", 32'(bus.Cnt_up), 32'(dir));
    chk("load_cnt_zero", 32'(bus.Period_cnt), 0);
    @(negedge CLK);
    chk("run_ld_low", 32'(bus.Cnt_ld), 0);
    chk("run_en_high", 32'(bus.Cnt_en), 1);
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned i = 0;
    do begin
      @(negedge CLK);
      i++;
    end while (bus.Done !== 1'b1 && i < max);
    if (bus.Done !== 1'b1) chk("timeout_done", 32'(bus.Done), 1);
  endtask

  task automatic wait_tc(input int unsigned n, input int unsigned max);
    int unsigned i = 0;
    while (tc_run != n && i < max) begin
      @(negedge CLK);
      i++;
    end
    if (tc_run != n) chk("timeout_tc", tc_run, n);
  endtask

  task automatic check_idle(input string name, input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge CLK);
      chk(name, {30'd0, bus.Busy, bus.Cnt_ld}, 0);
    end
  endtask

  initial begin
    int unsigned i;

    // Reset with Go held: nothing may leave IDLE.
    Clrn        = 1'b0;
    bus.Go      = 1'b1;
    bus.Stop    = 1'b0;
    bus.Dir_sel = 1'b1;
    bus.Periods = PW'(3);
    #12;
    chk("rst_ld", 32'(bus.Cnt_ld), 0);
    chk("rst_en", 32'(bus.Cnt_en), 0);
    chk("rst_up", 32'(bus.Cnt_up), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_period_cnt", 32'(bus.Period_cnt), 0);
    #2 bus.Go = 1'b0;
    #6 Clrn = 1'b1;
    check_idle("post_rst_idle", 2);

`ifndef AUTO_RELOAD_EN
    // Plain up run of three periods.
    push_exp(1'b1, 3);
    start_run(3, 1'b1);
    wait_done(60);
    chk("done_busy_low", 32'(bus.Busy), 0);
    @(negedge CLK);
    chk("done_one_cycle", 32'(bus.Done), 0);
    chk("done_to_idle", 32'(bus.Busy), 0);

    // Five periods with a direction change after the second terminal count.
    push_exp(1'b1, 5);
    start_run(5, 1'b1);
    wait_tc(2, 40);
    chk("dir_before_change", 32'(bus.Cnt_up), 1);
    bus.Dir_sel = 1'b0;
    @(negedge CLK);
    chk("dir_lag_one", 32'(bus.Cnt_up), 0);
    wait_done(80);
    chk("done5_busy_low", 32'(bus.Busy), 0);
`endif

    // Stop coincident with the second terminal count; Go mid-run must be ignored.
    push_exp(1'b0, 1);
    start_run(4, 1'b1);
    wait_tc(1, 20);
    @(negedge CLK);
    bus.Go      = 1'b1;
    bus.Periods = PW'(7);
    @(negedge CLK);
    bus.Go      = 1'b0;
    bus.Periods = PW'(4);
    i = 0;
    while (!(bus.Cnt_tc && tc_run == 1) && i < 30) begin
      @(negedge CLK);
      i++;
    end
    if (!(bus.Cnt_tc && tc_run == 1)) chk("timeout_second_tc", tc_run, 1);
    bus.Stop = 1'b1;
    @(posedge CLK);
    #1 bus.Stop = 1'b0;
    @(negedge CLK);
    chk("stop_busy", 32'(bus.Busy), 0);
    chk("stop_en", 32'(bus.Cnt_en), 0);
    chk("stop_done", 32'(bus.Done), 0);
    chk("stop_period_cnt", 32'(bus.Period_cnt), 1);
    check_idle("stop_stays_idle", 4);

    // Go with zero periods is ignored.
    @(negedge CLK);
    bus.Periods = '0;
    bus.Go      = 1'b1;
    @(negedge CLK);
    bus.Go = 1'b0;
    check_idle("zero_periods_idle", 4);

    // Asynchronous reset in the middle of a run.
    push_exp(1'b0, 0);
    start_run(3, 1'b1);
    repeat (12) @(negedge CLK);
    @(posedge CLK);
    #3 Clrn = 1'b0;
    #1;
    chk("midrst_ld", 32'(bus.Cnt_ld), 0);
    chk("midrst_en", 32'(bus.Cnt_en), 0);
    chk("midrst_up", 32'(bus.Cnt_up), 0);
    chk("midrst_busy", 32'(bus.Busy), 0);
    chk("midrst_period_cnt", 32'(bus.Period_cnt), 0);
    @(posedge CLK);
    #3 Clrn = 1'b1;
    check_idle("midrst_needs_go", 5);

`ifdef AUTO_RELOAD_EN
    // Auto-reload: three back-to-back two-period runs, then Stop while in DONE.
    push_exp(1'b1, 2);
    push_exp(1'b1, 2);
    push_exp(1'b1, 2);
    start_run(2, 1'b1);
    for (int k = 0; k < 3; k++) wait_done(40);
    bus.Stop = 1'b1;
    @(posedge CLK);
    #1 bus.Stop = 1'b0;
    @(negedge CLK);
    chk("auto_stop_busy", 32'(bus.Busy), 0);
    chk("auto_stop_ld", 32'(bus.Cnt_ld), 0);
    check_idle("auto_stop_idle", 3);
`endif

    repeat (3) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish by 2ms");
    $fatal(1);
  end

endmodule
